// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment scan controller.
//   scan_state_e : scan FSM states (ST_GUARD only used when SSD_GUARD_EN is defined)
//   SEG_BLANK    : all segments off (active-low)
//   HEX_SEG      : 16-entry nibble -> active-low {g,f,e,d,c,b,a} table
package ssd_pkg;

  typedef enum logic [0:0] {
    ST_SHOW  = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Guard counter width covers GUARD_TICKS up to 15.
  localparam int unsigned GUARD_CNT_W = 4;

  // Index 0 first: 0..9, A, b, C, d, E, F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: combinational hex nibble to active-low seven-segment pattern.
//   nibble_i : hex digit to show
//   seg_o    : {g,f,e,d,c,b,a}, active-low
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a multi-digit seven-segment display.
// Display values go through a shadow register and are committed only at frame wrap,
// so a frame never mixes old and new digits.
// Optional build macro SSD_GUARD_EN: blank all anodes for GUARD_TICKS strobes between digits.
// Ports:
//   clock, greset        : system clock, synchronous active-high reset
//   scan_en              : one-cycle scan strobe
//   load, value, dp      : capture a new display value into the shadow register
//   digit_on             : live per-digit enable mask
//   load_ack             : one-cycle pulse after the shadow value is committed
//   an, seg, dp_n        : registered active-low display drives
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned GUARD_TICKS = 1
) (
  input  logic                    clock,
  input  logic                    greset,
  input  logic                    scan_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_on,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   advance;
  logic                   commit;

  logic [VAL_W-1:0]       shadow_value_q, active_value_q;
  logic [NUM_DIGITS-1:0]  shadow_dp_q, active_dp_q;
  logic                   pending_q, pending_d;

  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_n_q, dp_n_d;
  logic                   load_ack_q;

  logic [3:0]             cur_nibble;
  logic [6:0]             cur_seg;

`ifdef SSD_GUARD_EN
  logic [GUARD_CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [GUARD_CNT_W-1:0] unused_guard_ticks;
  assign unused_guard_ticks = GUARD_CNT_W'(GUARD_TICKS);
`endif

  // State register (scan FSM, digit index, guard counter).
  always_ff @(posedge clock) begin
    if (greset) begin
      state_q <= ST_SHOW;
      idx_q   <= '0;
`ifdef SSD_GUARD_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef SSD_GUARD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: decides when the digit index advances.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    advance = 1'b0;
`ifdef SSD_GUARD_EN
    cnt_d   = cnt_q;
    if (scan_en) begin
      case (state_q)
        ST_SHOW: begin
          state_d = ST_GUARD;
          cnt_d   = GUARD_CNT_W'(GUARD_TICKS);
        end
        ST_GUARD: begin
          cnt_d = cnt_q - GUARD_CNT_W'(1);
          // Last guard strobe: counter hits zero on this edge.
          if (cnt_q == GUARD_CNT_W'(1)) begin
            advance = 1'b1;
            state_d = ST_SHOW;
          end
        end
        default: state_d = ST_SHOW;
      endcase
    end
`else
    state_d = ST_SHOW;
    advance = scan_en;
`endif
    if (advance) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Commit only at frame wrap; uses the shadow as it stood before this edge.
  assign commit = advance && (idx_q == LAST_IDX) && pending_q;

  // A same-cycle load re-arms pending even while the old shadow commits.
  always_comb begin
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  // Shadow / active value registers and commit acknowledge.
  always_ff @(posedge clock) begin
    if (greset) begin
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      active_value_q <= '0;
      active_dp_q    <= '0;
      pending_q      <= 1'b0;
      load_ack_q     <= 1'b0;
    end else begin
      if (load) begin
        shadow_value_q <= value;
        shadow_dp_q    <= dp;
      end
      if (commit) begin
        active_value_q <= shadow_value_q;
        active_dp_q    <= shadow_dp_q;
      end
      pending_q  <= pending_d;
      load_ack_q <= commit;
    end
  end

  assign cur_nibble = 4'(active_value_q >> {idx_q, 2'b00});

  ssd_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

  // Output logic: show the current digit, or blank during guard.
  always_comb begin
    an_d   = '1;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (state_q == ST_SHOW) begin
      an_d   = ~((NUM_DIGITS'(1) << idx_q) & digit_on);
      seg_d  = cur_seg;
      dp_n_d = ~active_dp_q[idx_q];
    end
  end

  // Display output registers.
  always_ff @(posedge clock) begin
    if (greset) begin
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp_n     = dp_n_q;
  assign load_ack = load_ack_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: self-checking bench for ssd_scan_ctrl (4 digits).
// Honours SSD_GUARD_EN the same way as the design.
module tb_ssd_scan_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned GT = 1;
`ifdef SSD_GUARD_EN
  localparam int unsigned G = GT;
`else
  localparam int unsigned G = 0;
`endif
  localparam int unsigned SLOT  = 1 + G;
  localparam int unsigned FRAME = N * SLOT;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clock = 1'b0;
  logic        greset, scan_en, load;
  logic [15:0] value;
  logic [3:0]  dp, digit_on;
  logic        load_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  always #5 clock = ~clock;

  ssd_scan_ctrl #(.NUM_DIGITS(N), .GUARD_TICKS(GT)) dut (
    .clock    (clock),
    .greset   (greset),
    .scan_en  (scan_en),
    .load     (load),
    .value    (value),
    .dp       (dp),
    .digit_on (digit_on),
    .load_ack (load_ack),
    .an       (an),
    .seg      (seg),
    .dp_n     (dp_n)
  );

  typedef struct {
    logic        rst, se, ld;
    logic [15:0] val;
    logic [3:0]  d, don;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dpn_e, ack_e;
  } vec_t;
  vec_t tbl[$];

  int n_chk  = 0;
  int n_fail = 0;
  int ack_seen;

  // Reference model: strobe position within the frame plus value registers.
  int unsigned m_s;
  logic [15:0] m_aval, m_sval;
  logic [3:0]  m_adp, m_sdp;
  logic        m_pend;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_aval = '0; m_sval = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
  endtask

  // Drive one clock of inputs, predict outputs, compare against the model.
  task automatic step(input logic rst, input logic se, input logic ld,
                      input logic [15:0] val, input logic [3:0] d, input logic [3:0] don);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpn, e_ack, cm;
    int unsigned dig;
    greset = rst; scan_en = se; load = ld; value = val; dp = d; digit_on = don;
    e_an = 4'hF; e_seg = BL; e_dpn = 1'b1; e_ack = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      dig = m_s / SLOT;
      if ((m_s % SLOT) == 0) begin
        e_an  = ~((4'b0001 << dig) & don);
        e_seg = hex_tbl[4'(m_aval >> (4 * dig))];
        e_dpn = ~m_adp[dig];
      end
      cm = se && m_pend && (((m_s + 1) % FRAME) == 0);
      e_ack = cm;
      if (cm) begin
        m_aval = m_sval;
        m_adp  = m_sdp;
      end
      m_pend = ld ? 1'b1 : (cm ? 1'b0 : m_pend);
      if (ld) begin
        m_sval = val;
        m_sdp  = d;
      end
      if (se) m_s = (m_s + 1) % FRAME;
    end
    @(posedge clock);
    #1;
    check("model.an", 16'(an), 16'(e_an));
    check("model.seg", 16'(seg), 16'(e_seg));
    check("model.dp_n", 16'(dp_n), 16'(e_dpn));
    check("model.load_ack", 16'(load_ack), 16'(e_ack));
    if (load_ack) ack_seen++;
  endtask

  task automatic add(input logic rst, input logic se, input logic ld, input logic [15:0] val,
                     input logic [3:0] d, input logic [3:0] don, input logic [3:0] an_e,
                     input logic [6:0] seg_e, input logic dpn_e, input logic ack_e);
    vec_t v;
    v.rst = rst; v.se = se; v.ld = ld; v.val = val; v.d = d; v.don = don;
    v.an_e = an_e; v.seg_e = seg_e; v.dpn_e = dpn_e; v.ack_e = ack_e;
    tbl.push_back(v);
  endtask

  int lit;

  initial begin
    greset = 1'b1; scan_en = 1'b0; load = 1'b0; value = '0; dp = '0; digit_on = 4'hF;
    model_reset();
    ack_seen = 0;

    // Hand-derived vectors starting from reset.
    add(1,0,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(1,0,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(0,0,1,16'h1234,4'b0001,4'hF, 4'b1110,S0,1,0);
`ifdef SSD_GUARD_EN
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1110,S0,1,0);
    add(0,0,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1101,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1101,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1011,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b0111,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'hF,BL,1,1);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1110,S4,0,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1110,S4,0,0);
    add(0,0,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
`else
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1110,S0,1,0);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1101,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1101,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1011,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b0111,S0,1,1);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1110,S4,0,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1110,S4,0,0);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1101,S3,1,0);
    add(0,1,0,16'h0,4'h0,4'b0011, 4'b1101,S3,1,0);
    add(0,1,0,16'h0,4'h0,4'b0011, 4'b1111,S2,1,0);
    add(0,1,1,16'hAAAA,4'h0,4'b0011, 4'b1111,S1,1,0);
    add(0,0,1,16'h5555,4'h0,4'hF, 4'b1110,S4,0,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1110,S4,0,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1101,S3,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1011,S2,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b0111,S1,1,1);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1110,S5,1,0);
    add(0,1,1,16'h8888,4'hF,4'hF, 4'b1110,S5,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1101,S5,1,0);
    add(1,1,0,16'h0,4'h0,4'hF, 4'hF,BL,1,0);
    add(0,0,0,16'h0,4'h0,4'hF, 4'b1110,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1110,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1101,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b1011,S0,1,0);
    add(0,1,0,16'h0,4'h0,4'hF, 4'b0111,S0,1,0);
`endif
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].se, tbl[i].ld, tbl[i].val, tbl[i].d, tbl[i].don);
      check($sformatf("vec%0d.an", i), 16'(an), 16'(tbl[i].an_e));
      check($sformatf("vec%0d.seg", i), 16'(seg), 16'(tbl[i].seg_e));
      check($sformatf("vec%0d.dp_n", i), 16'(dp_n), 16'(tbl[i].dpn_e));
      check($sformatf("vec%0d.ack", i), 16'(load_ack), 16'(tbl[i].ack_e));
    end

    // Load 1234 with scan_en every 4 clocks: exactly one ack over two frames.
    step(1,0,0,16'h0,4'h0,4'hF);
    step(1,0,0,16'h0,4'h0,4'hF);
    step(0,0,1,16'h1234,4'h0,4'hF);
    ack_seen = 0;
    for (int k = 0; k < int'(2 * FRAME * 4); k++) begin
      step(0, (k % 4) == 3, 0, 16'h0, 4'h0, 4'hF);
    end
    check("one_ack_1234", 16'(ack_seen), 16'd1);

    // 8888 with digit_on=0011: upper anodes stay off, lower digits show 8.
    step(0,0,1,16'h8888,4'h0,4'hF);
    for (int k = 0; k < int'(FRAME); k++) step(0,1,0,16'h0,4'h0,4'b0011);
    lit = 0;
    for (int k = 0; k < int'(FRAME); k++) begin
      step(0,1,0,16'h0,4'h0,4'b0011);
      check("mask_an_hi", 16'(an[3:2]), 16'(2'b11));
      if (an[1:0] != 2'b11) begin
        lit++;
        check("mask_seg8", 16'(seg), 16'(S8));
      end
    end
    check("mask_lit_count", 16'(lit), 16'd2);

    // Reset mid-frame at index 2 with a load pending: no ack, value 0 shown.
    for (int k = 0; k < int'(2 * SLOT); k++) step(0,1,0,16'h0,4'h0,4'hF);
    step(0,0,1,16'hFFFF,4'hF,4'hF);
    step(1,0,0,16'h0,4'h0,4'hF);
    ack_seen = 0;
    for (int k = 0; k < int'(2 * FRAME); k++) begin
      step(0,1,0,16'h0,4'h0,4'hF);
      if (an != 4'hF) check("rst_seg0", 16'(seg), 16'(S0));
    end
    check("rst_no_ack", 16'(ack_seen), 16'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0),
           16'($urandom),
           4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
